pnc_stmc_dispatch: RTL and testbench

Parametrised packet dispatcher for the Physical Neuron Controller STMC path. It accepts address packets through a valid/ready handshake and buffers them in a small FIFO. Each packet is classified as parameter, rich-club spike, local spike or null. Parameter and rich-club packets produce one command each; a local spike packet produces one command per non-zero address slot, lowest slot first. With defaults (2 slots × 7 bits, 16-bit packet) the classification matches the legacy single-cycle STMC control decode, and the block adds buffering, back-pressure, multi-slot serialisation and statistics.

---
 rtl/pnc_stmc_dispatch.sv | 153 +++++++++++++++
 tb/tb_pnc_stmc_dispatch.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pnc_stmc_dispatch.sv
// STMC packet dispatcher: a FIFO-buffered classifier that turns address packets into
// param, rich-club and per-slot spike commands, and keeps saturating statistics.
module pnc_stmc_dispatch #(
    parameter int N_SLOTS    = 2,
    parameter int SLOT_W     = 7,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16,
    localparam int PKT_W     = 2 + N_SLOTS * SLOT_W,
    localparam int IDX_W     = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PKT_W-1:0]  in_pkt,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [1:0]        cmd_type,
    output logic [SLOT_W-1:0] cmd_addr,
    output logic [IDX_W-1:0]  cmd_slot,
    output logic              cmd_last,
    output logic [PKT_W-1:0]  cmd_raw,
    output logic [CNT_W-1:0]  null_cnt,
    output logic [CNT_W-1:0]  cmd_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [1:0] TYPE_PARAM = 2'b01;
    localparam logic [1:0] TYPE_RICH  = 2'b10;
    localparam logic [1:0] TYPE_SPIKE = 2'b11;

    typedef enum logic {IDLE, EMIT} state_t;

    function automatic logic [N_SLOTS-1:0] slot_mask(input logic [PKT_W-1:0] pkt);
        logic [N_SLOTS-1:0] m;
        for (int i = 0; i < N_SLOTS; i++) m[i] = |pkt[i*SLOT_W +: SLOT_W];
        return m;
    endfunction

    function automatic logic [IDX_W-1:0] lowest_slot(input logic [N_SLOTS-1:0] m);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) if (m[i]) idx = IDX_W'(i);
        return idx;
    endfunction

    function automatic logic [SLOT_W-1:0] slot_field(input logic [PKT_W-1:0] pkt,
                                                     input logic [IDX_W-1:0] idx);
        logic [SLOT_W-1:0] f;
        f = '0;
        for (int i = 0; i < N_SLOTS; i++) if (idx == IDX_W'(i)) f = pkt[i*SLOT_W +: SLOT_W];
        return f;
    endfunction

    function automatic logic [N_SLOTS-1:0] drop_lowest(input logic [N_SLOTS-1:0] m);
        return m & (m - N_SLOTS'(1));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (&x) ? x : x + CNT_W'(1);
    endfunction

    logic [PKT_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr, rd_ptr;
    logic               fifo_full, fifo_empty, push, pop;
    logic [PKT_W-1:0]   head;
    logic [N_SLOTS-1:0] head_mask, head_rest, rem_mask, nxt_rest;
    logic [IDX_W-1:0]   head_idx, nxt_idx;
    state_t             state;

    // Extra pointer bit distinguishes full from empty when the indices coincide.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign in_ready   = !fifo_full;
    assign push       = in_valid && !fifo_full;
    assign pop        = (state == IDLE) && !fifo_empty;

    assign head      = mem[rd_ptr[PTR_W-1:0]];
    assign head_mask = slot_mask(head);
    assign head_idx  = lowest_slot(head_mask);
    assign head_rest = drop_lowest(head_mask);
    assign nxt_idx   = lowest_slot(rem_mask);
    assign nxt_rest  = drop_lowest(rem_mask);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= in_pkt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            state     <= IDLE;
            rem_mask  <= '0;
            cmd_valid <= 1'b0;
            cmd_type  <= 2'b00;
            cmd_addr  <= '0;
            cmd_slot  <= '0;
            cmd_last  <= 1'b0;
            cmd_raw   <= '0;
            null_cnt  <= '0;
            cmd_cnt   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            case (state)
                IDLE: begin
                    if (pop) begin
                        rd_ptr <= rd_ptr + (PTR_W+1)'(1);
                        if (head[PKT_W-1] || head[PKT_W-2]) begin
                            cmd_valid <= 1'b1;
                            cmd_type  <= head[PKT_W-1] ? TYPE_PARAM : TYPE_RICH;
                            cmd_addr  <= head[SLOT_W-1:0];
                            cmd_slot  <= '0;
                            cmd_last  <= 1'b1;
                            cmd_raw   <= head;
                            rem_mask  <= '0;
                            state     <= EMIT;
                        end else if (|head_mask) begin
                            cmd_valid <= 1'b1;
                            cmd_type  <= TYPE_SPIKE;
                            cmd_addr  <= slot_field(head, head_idx);
                            cmd_slot  <= head_idx;
                            cmd_last  <= (head_rest == '0);
                            cmd_raw   <= head;
                            rem_mask  <= head_rest;
                            state     <= EMIT;
                        end else begin
                            null_cnt  <= sat_inc(null_cnt);
                        end
                    end
                end
                EMIT: begin
                    if (cmd_ready) begin
                        cmd_cnt <= sat_inc(cmd_cnt);
                        if (cmd_last) begin
                            cmd_valid <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            // Next slot loads on the handshake edge: no bubble inside a packet.
                            cmd_addr  <= slot_field(cmd_raw, nxt_idx);
                            cmd_slot  <= nxt_idx;
                            cmd_last  <= (nxt_rest == '0);
                            rem_mask  <= nxt_rest;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pnc_stmc_dispatch.sv
// Bench for pnc_stmc_dispatch: directed literal checks plus randomized traffic
// compared every cycle against a queue-based transaction model.
module tb_pnc_stmc_dispatch;

    localparam int N_SLOTS = 2;
    localparam int SLOT_W  = 7;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 6;
    localparam int PKT_W   = 2 + N_SLOTS * SLOT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [PKT_W-1:0]  in_pkt = '0;
    logic              cmd_valid;
    logic              cmd_ready = 1'b0;
    logic [1:0]        cmd_type;
    logic [SLOT_W-1:0] cmd_addr;
    logic [0:0]        cmd_slot;
    logic              cmd_last;
    logic [PKT_W-1:0]  cmd_raw;
    logic [CNT_W-1:0]  null_cnt;
    logic [CNT_W-1:0]  cmd_cnt;

    pnc_stmc_dispatch #(.N_SLOTS(N_SLOTS), .SLOT_W(SLOT_W), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pkt(in_pkt),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type), .cmd_addr(cmd_addr),
        .cmd_slot(cmd_slot), .cmd_last(cmd_last), .cmd_raw(cmd_raw),
        .null_cnt(null_cnt), .cmd_cnt(cmd_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]        typ;
        logic [SLOT_W-1:0] addr;
        logic [0:0]        slot;
        logic              last;
        logic [PKT_W-1:0]  raw;
    } cmd_t;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model: packets waiting in the input buffer, and commands still owed for the packet in hand.
    logic [PKT_W-1:0] fifo_q[$];
    cmd_t             work_q[$];
    logic [CNT_W-1:0] m_null = '0;
    logic [CNT_W-1:0] m_cmd  = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic expand(input logic [PKT_W-1:0] p);
        cmd_t c;
        int   nz, k;
        if (p[PKT_W-1] || p[PKT_W-2]) begin
            c.typ = p[PKT_W-1] ? 2'b01 : 2'b10;
            c.addr = p[SLOT_W-1:0];
            c.slot = 1'b0;
            c.last = 1'b1;
            c.raw = p;
            work_q.push_back(c);
        end else begin
            nz = 0;
            for (int i = 0; i < N_SLOTS; i++) if (p[i*SLOT_W +: SLOT_W] != 0) nz++;
            if (nz == 0) begin
                if (m_null != CNT_MAX) m_null = m_null + 1'b1;
            end else begin
                k = 0;
                for (int i = 0; i < N_SLOTS; i++) begin
                    if (p[i*SLOT_W +: SLOT_W] != 0) begin
                        k++;
                        c.typ = 2'b11;
                        c.addr = p[i*SLOT_W +: SLOT_W];
                        c.slot = 1'(i);
                        c.last = (k == nz);
                        c.raw = p;
                        work_q.push_back(c);
                    end
                end
            end
        end
    endtask

    task automatic model_step();
        bit acc;
        if (rst) begin
            fifo_q.delete();
            work_q.delete();
            m_null = '0;
            m_cmd = '0;
        end else begin
            acc = in_valid && (fifo_q.size() < DEPTH);
            if (work_q.size() > 0) begin
                if (cmd_ready) begin
                    void'(work_q.pop_front());
                    if (m_cmd != CNT_MAX) m_cmd = m_cmd + 1'b1;
                end
            end else if (fifo_q.size() > 0) begin
                expand(fifo_q.pop_front());
            end
            if (acc) fifo_q.push_back(in_pkt);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("in_ready", in_ready, fifo_q.size() < DEPTH);
            check("cmd_valid", cmd_valid, work_q.size() > 0);
            if (work_q.size() > 0) begin
                check("cmd_type", cmd_type, work_q[0].typ);
                check("cmd_addr", cmd_addr, work_q[0].addr);
                check("cmd_slot", cmd_slot, work_q[0].slot);
                check("cmd_last", cmd_last, work_q[0].last);
                check("cmd_raw", cmd_raw, work_q[0].raw);
            end
            check("null_cnt", null_cnt, m_null);
            check("cmd_cnt", cmd_cnt, m_cmd);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [PKT_W-1:0] p);
        int guard;
        in_valid = 1'b1;
        in_pkt = p;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) check("push_timeout", 1, 0);
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [PKT_W-1:0] rand_pkt();
        logic [PKT_W-1:0] p;
        logic [SLOT_W-1:0] s0, s1;
        s0 = ($urandom_range(0, 9) < 4) ? '0 : SLOT_W'($urandom);
        s1 = ($urandom_range(0, 9) < 4) ? '0 : SLOT_W'($urandom);
        case ($urandom_range(0, 5))
            0:       p = '0;
            1:       p = {1'b1, 1'($urandom), s1, s0};
            2:       p = {2'b01, s1, s0};
            default: p = {2'b00, s1, s0};
        endcase
        return p;
    endfunction

    initial begin
        int acc_n, guard;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_type", cmd_type, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_null_cnt", null_cnt, 0);
        check("rst_cmd_cnt", cmd_cnt, 0);
        check("rst_cmd_raw", cmd_raw, 0);
        check("rst_cmd_last", cmd_last, 0);
        rst = 1'b0;
        chk_en = 1'b1;
        tick();

        // Param packet
        cmd_ready = 1'b1;
        push(16'h8123);
        check("param_valid_early", cmd_valid, 0);
        tick();
        check("param_valid", cmd_valid, 1);
        check("param_type", cmd_type, 2'b01);
        check("param_addr", cmd_addr, 7'h23);
        check("param_slot", cmd_slot, 0);
        check("param_last", cmd_last, 1);
        check("param_raw", cmd_raw, 16'h8123);
        tick();
        check("param_done", cmd_valid, 0);
        check("param_cnt", cmd_cnt, 1);

        // Rich-club packet
        push(16'h4005);
        tick();
        check("rich_type", cmd_type, 2'b10);
        check("rich_addr", cmd_addr, 7'h05);
        check("rich_last", cmd_last, 1);
        tick();

        // Two-slot spike under back-pressure
        cmd_ready = 1'b0;
        push(16'h0283);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("spk0_type", cmd_type, 2'b11);
            check("spk0_addr", cmd_addr, 7'h03);
            check("spk0_slot", cmd_slot, 0);
            check("spk0_last", cmd_last, 0);
            tick();
        end
        cmd_ready = 1'b1;
        tick();
        check("spk1_valid", cmd_valid, 1);
        check("spk1_addr", cmd_addr, 7'h05);
        check("spk1_slot", cmd_slot, 1);
        check("spk1_last", cmd_last, 1);
        tick();
        check("spk_done", cmd_valid, 0);
        check("spk_cnt", cmd_cnt, 4);

        // Null followed by a packet with only slot 1 set
        push(16'h0000);
        push(16'h0180);
        check("null_cnt1", null_cnt, 1);
        check("null_no_cmd", cmd_valid, 0);
        tick();
        check("skip_type", cmd_type, 2'b11);
        check("skip_addr", cmd_addr, 7'h03);
        check("skip_slot", cmd_slot, 1);
        check("skip_last", cmd_last, 1);
        tick();
        tick();

        // Back-pressure: six offers, five fit
        cmd_ready = 1'b0;
        acc_n = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_pkt = {2'b00, 7'(i + 1), 7'(i + 10)};
            if (i == 5) check("bp_in_ready6", in_ready, 0);
            if (in_ready) acc_n++;
            tick();
        end
        in_valid = 1'b0;
        check("bp_accepted", acc_n, 5);
        cmd_ready = 1'b1;
        repeat (20) tick();
        check("bp_cmd_cnt", cmd_cnt, 15);
        check("bp_null_cnt", null_cnt, 1);

        // Reset in the middle of EMIT
        cmd_ready = 1'b0;
        push(16'h0283);
        push(16'h8011);
        push(16'h0102);
        guard = 0;
        while (!cmd_valid && guard < 20) begin
            tick();
            guard++;
        end
        check("rst_mid_emit_reached", cmd_valid, 1);
        rst = 1'b1;
        tick();
        check("rst_mid_valid", cmd_valid, 0);
        check("rst_mid_in_ready", in_ready, 1);
        check("rst_mid_cmd_cnt", cmd_cnt, 0);
        rst = 1'b0;
        cmd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rst_no_stale", cmd_valid, 0);
        end

        // Randomized traffic with one reset mid-run
        for (int c = 0; c < 3000; c++) begin
            rst = (c == 1500);
            in_valid = ($urandom_range(0, 9) < 6);
            in_pkt = rand_pkt();
            cmd_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        cmd_ready = 1'b1;
        repeat (30) tick();
        check("drain_idle", cmd_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
